input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 1_000_000; it is the stable-sample count required to accept a level (10 ms at 100 MHz).
REQ-003 Parameter SYNC_STAGES SHALL default to 2; it is the flip-flop depth of each input synchronizer, minimum 2.
REQ-004 Port list SHALL be (name, direction, width, meaning):
 clk  in  1  system clock
 reset  in  1  synchronous active-high reset
 btn_raw  in  1  asynchronous confirm push-button
 sw_raw  in  16  asynchronous slide switches
 value  out  16  switch snapshot taken at the accepted press
 user_confirm  out  1  one-cycle pulse per accepted press; drives the processor's user_confirm input
 held  out  1  debounced button level
 press_count  out  8  count of accepted presses, for diagnostics

Function
REQ-005 btn_raw and each sw_raw bit SHALL pass through a SYNC_STAGES-deep synchronizer before any use; the outputs are btn_sync and sw_sync.
REQ-006 The FSM SHALL have four states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-007 In RELEASED with btn_sync=1, the FSM SHALL move to PRESS_PEND and clear the counter.
REQ-008 In PRESS_PEND with btn_sync=0, the FSM SHALL return to RELEASED (bounce rejected); no output changes.
REQ-009 In PRESS_PEND with btn_sync=1, the counter SHALL increment; when counter=DEBOUNCE_CYCLES-1, the FSM SHALL move to PRESSED.
REQ-010 On the edge entering PRESSED, user_confirm SHALL go high for exactly one cycle, value SHALL load sw_sync, and press_count SHALL increment.
REQ-011 In PRESSED with btn_sync=0, the FSM SHALL move to RELEASE_PEND and clear the counter.
REQ-012 In RELEASE_PEND, btn_sync=1 SHALL return the FSM to PRESSED with no new pulse; DEBOUNCE_CYCLES consecutive zeros SHALL move it to RELEASED.
REQ-013 held SHALL be 1 in PRESSED and RELEASE_PEND, and 0 otherwise.
REQ-014 Latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 clock edges from btn_raw rising stably before edge k to user_confirm high.
REQ-015 value SHALL hold its contents between accepted presses; switch changes while held=1 SHALL be ignored.
REQ-016 press_count SHALL wrap from 255 to 0 without other side effects.
REQ-017 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-018 A button held for any duration SHALL produce exactly one user_confirm pulse.

Reset
REQ-019 On reset, the FSM SHALL go to RELEASED; counter, synchronizer flops, value, user_confirm, held and press_count SHALL all be 0.
REQ-020 Reset asserted mid-debounce or mid-press SHALL abort without emitting a pulse.
REQ-021 A button still held when reset is released SHALL be treated as a new press and re-debounced from zero.

Structure
REQ-022 The state typedef (ic_state_t) and the DEBOUNCE_CYCLES_DEFAULT and SYNC_STAGES_DEFAULT constants SHALL live in the shared package procco_pkg.
REQ-023 One sub-module, sync_ff (parameterized WIDTH and STAGES, synchronous reset), SHALL be instantiated twice: for btn (1 bit) and for sw (16 bits).
REQ-024 The top level SHALL instantiate input_conditioner ahead of the processor and route user_confirm and value to it.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-025 sw_raw=16'hBEEF; btn_raw 0->1 held 20 cycles -> user_confirm high exactly 1 cycle at edge 7; value=16'hBEEF; press_count=1; held=1.
REQ-026 btn_raw pulses high for 2 cycles, 3 times, with 2-cycle gaps -> no user_confirm; value=0; press_count=0.
REQ-027 Accepted press, then sw_raw changes to 16'h1234 while held, then release and re-press -> value stays 16'hBEEF until the second pulse, then becomes 16'h1234; press_count=2.
REQ-028 While PRESSED, btn_raw drops for 2 cycles then returns -> no second pulse; held stays 1.
REQ-029 256 clean presses -> press_count wraps to 0; exactly 256 pulses counted.
REQ-030 reset asserted in PRESS_PEND with the button still held -> no pulse during reset; after reset release, one pulse occurs 7 edges later.

Source files
------------

// File: rtl/procco_pkg.sv
// Shared types and constants for the processor's input-conditioning front end.
package procco_pkg;

    // Button debounce FSM states.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } ic_state_t;

    // 10 ms of stable samples at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

    localparam int unsigned SW_W        = 16;
    localparam int unsigned PRESS_CNT_W = 8;

    // Debounced button level: high while pressed or while a release is being confirmed.
    function automatic logic ic_is_held(input ic_state_t s);
        return (s == PRESSED) || (s == RELEASE_PEND);
    endfunction

endpackage : procco_pkg

// File: rtl/input_conditioner_if.sv
// Board-side button/switch inputs and conditioned outputs toward the processor.
interface input_conditioner_if;

    logic                                  btn_raw;
    logic [procco_pkg::SW_W-1:0]           sw_raw;
    logic [procco_pkg::SW_W-1:0]           value;
    logic                                  user_confirm;
    logic                                  held;
    logic [procco_pkg::PRESS_CNT_W-1:0]    press_count;

    // Board / stimulus side.
    modport master (
        output btn_raw,
        output sw_raw,
        input  value,
        input  user_confirm,
        input  held,
        input  press_count
    );

    // Conditioner side.
    modport slave (
        input  btn_raw,
        input  sw_raw,
        output value,
        output user_confirm,
        output held,
        output press_count
    );

endinterface : input_conditioner_if

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous inputs, synchronous reset.
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Fewer than two stages gives no metastability protection, so clamp.
    localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Shift the new sample in at stage 0.
    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], d};
    end

    // Synchronizer register chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule : sync_ff

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the confirm button, snapshots the switches on each
// accepted press and emits a single-cycle user_confirm pulse for the processor.
module input_conditioner
    import procco_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input_conditioner_if.slave   ic
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                   btn_sync;
    logic [SW_W-1:0]        sw_sync;

    ic_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SW_W-1:0]        value_q, value_d;
    logic                   user_confirm_q, user_confirm_d;
    logic                   held_q, held_d;
    logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

    sync_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ic.btn_raw),
        .q     (btn_sync)
    );

    sync_ff #(
        .WIDTH  (SW_W),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ic.sw_raw),
        .q     (sw_sync)
    );

    // Debounce FSM: next state, counter and registered-output next values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        value_d        = value_q;
        press_count_d  = press_count_q;
        user_confirm_d = 1'b0;

        unique case (state_q)
            RELEASED: begin
                if (btn_sync) begin
                    state_d = PRESS_PEND;
                    cnt_d   = '0;
                end
            end
            PRESS_PEND: begin
                if (!btn_sync) begin
                    // Bounce: drop back without touching any output.
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = PRESSED;
                    cnt_d          = '0;
                    user_confirm_d = 1'b1;
                    value_d        = sw_sync;
                    press_count_d  = press_count_q + PRESS_CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = '0;
                end
            end
            RELEASE_PEND: begin
                if (btn_sync) begin
                    // Release glitch: still the same press, no new pulse.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        held_d = ic_is_held(state_d);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RELEASED;
            cnt_q          <= '0;
            value_q        <= '0;
            user_confirm_q <= 1'b0;
            held_q         <= 1'b0;
            press_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            value_q        <= value_d;
            user_confirm_q <= user_confirm_d;
            held_q         <= held_d;
            press_count_q  <= press_count_d;
        end
    end

    assign ic.value        = value_q;
    assign ic.user_confirm = user_confirm_q;
    assign ic.held         = held_q;
    assign ic.press_count  = press_count_q;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a run-length reference model of the debounce rules.
module tb_input_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    input_conditioner_if bus();

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ic    (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int pulses = 0;

    // Reference model: inputs arrive S samples late; a level is accepted after
    // D+1 consecutive identical samples opposing the current debounced level.
    logic        m_pipe_b [S];
    logic [15:0] m_pipe_s [S];
    logic        m_last = 1'b0;
    int          m_run = 0;
    logic        m_level = 1'b0;
    logic        m_pulse = 1'b0;
    logic [15:0] m_value = '0;
    logic [7:0]  m_count = '0;
    int          m_pulses = 0;

    always @(posedge clk) begin
        logic        smp;
        logic [15:0] ssmp;
        if (reset) begin
            for (int i = 0; i < int'(S); i++) begin
                m_pipe_b[i] = 1'b0;
                m_pipe_s[i] = '0;
            end
            m_last = 1'b0; m_run = 0; m_level = 1'b0; m_pulse = 1'b0;
            m_value = '0; m_count = '0;
        end else begin
            smp  = m_pipe_b[S-1];
            ssmp = m_pipe_s[S-1];
            for (int i = int'(S) - 1; i > 0; i--) begin
                m_pipe_b[i] = m_pipe_b[i-1];
                m_pipe_s[i] = m_pipe_s[i-1];
            end
            m_pipe_b[0] = bus.btn_raw;
            m_pipe_s[0] = bus.sw_raw;
            m_pulse = 1'b0;
            if (smp == m_last) m_run = (m_run < 1000) ? m_run + 1 : 1000;
            else m_run = 1;
            m_last = smp;
            if (!m_level && smp && m_run == int'(D) + 1) begin
                m_level = 1'b1; m_pulse = 1'b1; m_value = ssmp;
                m_count = m_count + 8'd1; m_pulses++;
            end else if (m_level && !smp && m_run == int'(D) + 1) begin
                m_level = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus.user_confirm === 1'b1) pulses++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.btn_raw = 1'b1;
        bus.sw_raw  = 16'hFFFF;
        do_reset(3);
        total++; if (bus.user_confirm !== 1'b0) begin bad++; $display("FAIL reset_confirm got=%b exp=0", bus.user_confirm); end
        total++; if (bus.held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b exp=0", bus.held); end
        total++; if (bus.value !== 16'h0) begin bad++; $display("FAIL reset_value got=%h exp=0000", bus.value); end
        total++; if (bus.press_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.press_count); end
        bus.btn_raw = 1'b0;
        do_reset(2);
        repeat (4) tick();
    endtask

    task automatic test_clean_press();
        int p0;
        do_reset(2);
        bus.sw_raw = 16'hBEEF;
        repeat (3) tick();
        p0 = pulses;
        bus.btn_raw = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            total++;
            if (bus.user_confirm !== logic'(n == 7)) begin
                bad++; $display("FAIL press_latency edge=%0d got=%b exp=%b", n, bus.user_confirm, n == 7);
            end
            total++;
            if ({bus.user_confirm, bus.held, bus.value, bus.press_count} !== {m_pulse, m_level, m_value, m_count}) begin
                bad++; $display("FAIL press_model edge=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", n,
                    bus.user_confirm, bus.held, bus.value, bus.press_count, m_pulse, m_level, m_value, m_count);
            end
        end
        total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL press_pulses got=%0d exp=1", pulses - p0); end
        total++; if (bus.value !== 16'hBEEF) begin bad++; $display("FAIL press_value got=%h exp=beef", bus.value); end
        total++; if (bus.press_count !== 8'd1) begin bad++; $display("FAIL press_count got=%0d exp=1", bus.press_count); end
        total++; if (bus.held !== 1'b1) begin bad++; $display("FAIL press_held got=%b exp=1", bus.held); end
        bus.btn_raw = 1'b0;
        repeat (10) tick();
        total++; if (bus.held !== 1'b0) begin bad++; $display("FAIL release_held got=%b exp=0", bus.held); end
    endtask

    task automatic test_bounce();
        int p0;
        do_reset(2);
        bus.sw_raw = 16'hBEEF;
        p0 = pulses;
        for (int k = 0; k < 3; k++) begin
            bus.btn_raw = 1'b1;
            repeat (2) tick();
            bus.btn_raw = 1'b0;
            repeat (2) tick();
        end
        repeat (10) tick();
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", pulses - p0); end
        total++; if (bus.value !== 16'h0) begin bad++; $display("FAIL bounce_value got=%h exp=0000", bus.value); end
        total++; if (bus.press_count !== 8'd0) begin bad++; $display("FAIL bounce_count got=%0d exp=0", bus.press_count); end
    endtask

    task automatic test_value_snapshot();
        logic seen;
        do_reset(2);
        bus.sw_raw = 16'hBEEF;
        bus.btn_raw = 1'b1;
        repeat (12) tick();
        total++; if (bus.value !== 16'hBEEF) begin bad++; $display("FAIL snap_first got=%h exp=beef", bus.value); end
        bus.sw_raw = 16'h1234;
        repeat (5) tick();
        total++; if (bus.value !== 16'hBEEF) begin bad++; $display("FAIL snap_held got=%h exp=beef", bus.value); end
        bus.btn_raw = 1'b0;
        repeat (10) tick();
        total++; if (bus.value !== 16'hBEEF) begin bad++; $display("FAIL snap_released got=%h exp=beef", bus.value); end
        bus.btn_raw = 1'b1;
        seen = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (bus.user_confirm === 1'b1) seen = 1'b1;
            total++;
            if (bus.value !== (seen ? 16'h1234 : 16'hBEEF)) begin
                bad++; $display("FAIL snap_second edge=%0d got=%h exp=%h", n, bus.value, seen ? 16'h1234 : 16'hBEEF);
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL snap_second_pulse got=%b exp=1", seen); end
        total++; if (bus.press_count !== 8'd2) begin bad++; $display("FAIL snap_count got=%0d exp=2", bus.press_count); end
        bus.btn_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_glitch_pressed();
        int p0;
        do_reset(2);
        bus.btn_raw = 1'b1;
        repeat (10) tick();
        p0 = pulses;
        bus.btn_raw = 1'b0;
        repeat (2) tick();
        bus.btn_raw = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            total++;
            if (bus.held !== 1'b1) begin bad++; $display("FAIL glitch_held cyc=%0d got=%b exp=1", n, bus.held); end
        end
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", pulses - p0); end
        bus.btn_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_wrap();
        int p0;
        do_reset(2);
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            bus.sw_raw = 16'(i);
            bus.btn_raw = 1'b1;
            repeat (8) tick();
            bus.btn_raw = 1'b0;
            repeat (8) tick();
            if (i == 254) begin
                total++;
                if (bus.press_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", bus.press_count); end
            end
        end
        total++; if (bus.press_count !== 8'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", bus.press_count); end
        total++; if (pulses - p0 !== 256) begin bad++; $display("FAIL wrap_pulses got=%0d exp=256", pulses - p0); end
        total++; if (bus.value !== 16'd255) begin bad++; $display("FAIL wrap_value got=%h exp=00ff", bus.value); end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        bus.btn_raw = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (bus.user_confirm !== 1'b0 || bus.held !== 1'b0) begin
                bad++; $display("FAIL rst_mid_hold cyc=%0d got=%b/%b exp=0/0", n, bus.user_confirm, bus.held);
            end
        end
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            total++;
            if (bus.user_confirm !== logic'(n == 7)) begin
                bad++; $display("FAIL rst_mid_latency edge=%0d got=%b exp=%b", n, bus.user_confirm, n == 7);
            end
        end
        total++; if (bus.press_count !== 8'd1) begin bad++; $display("FAIL rst_mid_count got=%0d exp=1", bus.press_count); end
        bus.btn_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int p0, mp0, len;
        do_reset(2);
        p0 = pulses;
        mp0 = m_pulses;
        for (int seg = 0; seg < 150; seg++) begin
            bus.btn_raw = ~bus.btn_raw;
            if ($urandom_range(0, 1) == 1) bus.sw_raw = 16'($urandom);
            len = int'($urandom_range(1, 9));
            for (int c = 0; c < len; c++) begin
                tick();
                total++;
                if ({bus.user_confirm, bus.held, bus.value, bus.press_count} !== {m_pulse, m_level, m_value, m_count}) begin
                    bad++; $display("FAIL random_model seg=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", seg,
                        bus.user_confirm, bus.held, bus.value, bus.press_count, m_pulse, m_level, m_value, m_count);
                end
            end
        end
        total++;
        if (pulses - p0 !== m_pulses - mp0) begin
            bad++; $display("FAIL random_pulses got=%0d exp=%0d", pulses - p0, m_pulses - mp0);
        end
    endtask

    initial begin
        bus.btn_raw = 1'b0;
        bus.sw_raw  = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_value_snapshot();
        test_glitch_pressed();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_conditioner
